gate_sweep_checker: RTL and testbench
=====================================

// Module: gate_sweep_checker
// PURPOSE
//  Synthesizable, self-checking exhaustive stimulus engine for N-input gate DUTs.
//  Parametrised successor to the fixed 2-input stepped-delay gate bench.
//  Sweeps every input combination in ascending order and holds each one for DWELL cycles.
//  Samples the DUT output and compares it with a selectable reference function.
//  Reports an error count, the first failing vector, and pass/done status.
//  Sits between a top-level test controller and any combinational gate DUT.
// PARAMETERS
//  N_IN   2  DUT input count; vectors 0 .. 2^N_IN-1; legal range 1..16
//  DWELL  5  cycles each vector is held; legal range >=2; sample taken on the last dwell cycle
//  ERR_W  8  error counter width; counter saturates at 2^ERR_W-1
// PORTS
//  clk              in   1      single clock, rising edge
//  rst              in   1      asynchronous, active-high reset
//  start            in   1      1-cycle pulse begins a sweep; ignored while busy=1
//  mode             in   2      reference function, latched on start: 0 AND, 1 OR, 2 XOR, 3 NAND
//  dut_in           out  N_IN   stimulus vector driven to the DUT
//  dut_out          in   1      DUT result
//  busy             out  1      sweep in progress
//  done             out  1      sweep finished; held until the next accepted start or reset
//  pass             out  1      valid when done=1; 1 iff err_count==0
//  err_count        out  ERR_W  mismatches in the current/last sweep, saturating
//  first_err_valid  out  1      at least one mismatch captured
//  first_err_vec    out  N_IN   vector of the first mismatch
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; vec_cnt=0; dwell_cnt=0; mode_q=0.
//  Reset is legal mid-sweep: outputs return to reset values immediately, with no partial done.
//  FSM: IDLE -> RUN -> DONE -> RUN on the next start (DONE also accepts start).
//  Sweep start:
//   - start=1 in IDLE/DONE at edge t: latch mode_q; clear err_count, first_err_*, done, pass.
//   - busy=1 and dut_in=0 from t+1.
//  RUN timing:
//   - dut_in=vec_cnt; dwell_cnt counts 0..DWELL-1.
//   - At dwell_cnt==DWELL-1, compare dut_out with ref(mode_q, vec_cnt).
//   - Then vec_cnt++ and dwell_cnt=0.
//  Reference functions:
//   - AND = &vec; OR = |vec; XOR = ^vec; NAND = ~&vec.
//  Mismatch handling:
//   - err_count += 1, saturating at all-ones.
//   - On the first mismatch only: first_err_vec=vec_cnt and first_err_valid=1.
//  End of sweep:
//   - Last vector (all ones) sampled at edge e -> from e+1: busy=0, done=1, pass=(err_count==0).
//   - err_count at that point includes the final sample.
//   - dut_in holds the last vector.
//   - Total run = 2^N_IN*DWELL cycles from the first busy cycle.
//  Wrap: vec_cnt is N_IN+1 bits internally so that the all-ones terminal vector is detected without aliasing to 0.
//  start while busy: no effect. start and rst together: rst wins.
//  mode changes mid-sweep: no effect (mode_q is used).
//  All outputs are registered; dut_out is sampled on one edge only, so DUT settle time = DWELL-1 cycles.
// STRUCTURE
//  Shared package gate_check_pkg:
//   - mode encodings MODE_AND/OR/XOR/NAND
//   - FSM state typedef / localparams S_IDLE, S_RUN, S_DONE
//   - function ref_gate(mode, vec)
//  Sub-module sat_counter #(W): saturating increment with synchronous clear; used for err_count.
//  The vector/dwell counters and FSM stay in this file.
// TESTING
//  1 Good AND DUT:
//   - Stimulus: N_IN=2, DWELL=5, mode=0, start at t0.
//   - Response: dut_in 0,1,2,3 for 5 cycles each; done at t0+21; pass=1; err_count=0.
//  2 Stuck-at-1 DUT:
//   - Stimulus: mode=0, dut_out tied 1.
//   - Response: err_count=3; first_err_vec=0; first_err_valid=1; pass=0.
//  3 Good XOR DUT with mode changes:
//   - Stimulus: N_IN=3, mode=2; mode toggled mid-sweep; start pulsed while busy.
//   - Response: no restart; done after 40 busy cycles; pass=1.
//  4 Saturation:
//   - Stimulus: ERR_W=2, N_IN=4, mode=3 (NAND), DUT implements AND.
//   - Response: 16 mismatches; err_count saturates at 3; first_err_vec=0.
//  5 Reset mid-sweep:
//   - Stimulus: rst pulse during vector 2; then a new start with a good DUT.
//   - Response: all outputs 0 asynchronously, no done pulse; new sweep from dut_in=0; pass=1.
//  6 Back-to-back sweeps:
//   - Stimulus: start while done=1 with a good OR DUT.
//   - Response: done/pass/err state cleared on accept; second sweep completes; pass=1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate sweep checker: reference-function encodings,
// FSM states and the golden gate function.
package gate_check_pkg;

    localparam logic [1:0] MODE_AND  = 2'd0;
    localparam logic [1:0] MODE_OR   = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_NAND = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // vec arrives zero-extended; n_in tells which bits form the "all ones" pattern.
    function automatic logic ref_gate(input logic [1:0] mode,
                                      input logic [15:0] vec,
                                      input int unsigned n_in);
        logic all_ones;
        all_ones = (vec == 16'((32'd1 << n_in) - 32'd1));
        case (mode)
            MODE_AND: return all_ones;
            MODE_OR:  return |vec;
            MODE_XOR: return ^vec;
            default:  return ~all_ones;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus engine for an N-input combinational gate: sweeps all
// vectors in ascending order, holds each DWELL cycles and checks the DUT result.
module gate_sweep_checker
    import gate_check_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int DWELL = 5,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
);

    localparam int               DW_W     = $clog2(DWELL);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    // One spare MSB keeps the all-ones terminal vector distinct from a wrap to 0.
    localparam logic [N_IN:0]    LAST_VEC = {1'b0, {N_IN{1'b1}}};

    state_t            r_state;
    state_t            w_state_next;
    logic [N_IN:0]     r_vec_cnt;
    logic [DW_W-1:0]   r_dwell_cnt;
    logic [1:0]        r_mode_q;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_first_err_valid;
    logic [N_IN-1:0]   r_first_err_vec;

    logic              w_accept;
    logic              w_sample;
    logic              w_last;
    logic              w_expected;
    logic              w_mismatch;
    logic              w_err_zero_next;

    assign w_accept   = start && (r_state != S_RUN);
    assign w_sample   = (r_state == S_RUN) && (r_dwell_cnt == DW_LAST);
    assign w_last     = w_sample && (r_vec_cnt == LAST_VEC);
    assign w_expected = ref_gate(r_mode_q, 16'(r_vec_cnt[N_IN-1:0]), N_IN);
    assign w_mismatch = w_sample && (dut_out != w_expected);
    // A saturating count never returns to zero, so this is exact even at the limit.
    assign w_err_zero_next = (err_count == '0) && !w_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first so no path through the case leaves a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  if (w_accept) w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_cnt         <= '0;
            r_dwell_cnt       <= '0;
            r_mode_q          <= MODE_AND;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
        end else begin
            r_busy <= (w_state_next == S_RUN);
            r_done <= (w_state_next == S_DONE);
            if (w_accept) begin
                r_mode_q          <= mode;
                r_vec_cnt         <= '0;
                r_dwell_cnt       <= '0;
                r_pass            <= 1'b0;
                r_first_err_valid <= 1'b0;
                r_first_err_vec   <= '0;
            end else if (r_state == S_RUN) begin
                if (w_sample) begin
                    if (w_mismatch && !r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_vec   <= r_vec_cnt[N_IN-1:0];
                    end
                    if (w_last) begin
                        r_pass <= w_err_zero_next;
                    end else begin
                        r_vec_cnt   <= r_vec_cnt + 1'b1;
                        r_dwell_cnt <= '0;
                    end
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_inc   (w_mismatch),
        .o_count (err_count)
    );

    assign dut_in          = r_vec_cnt[N_IN-1:0];
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign first_err_valid = r_first_err_valid;
    assign first_err_vec   = r_first_err_vec;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three parameterisations driven by a behavioural
// gate model with injectable faults, checked against a per-vector reference.
`timescale 1ns/1ps
module tb_gate_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [3];
    logic [1:0] mode_v  [3];

    logic       dout_a, dout_b, dout_c;
    logic [1:0] din_a;   logic [2:0] din_b;   logic [3:0] din_c;
    logic       busy_a,  busy_b,  busy_c;
    logic       done_a,  done_b,  done_c;
    logic       pass_a,  pass_b,  pass_c;
    logic [7:0] err_a,   err_b;   logic [1:0] err_c;
    logic       fev_a,   fev_b,   fev_c;
    logic [1:0] fvec_a;  logic [2:0] fvec_b;  logic [3:0] fvec_c;

    int          dut_fn;      // 0 AND 1 OR 2 XOR 3 NAND 4 stuck-1 5 stuck-0
    logic [15:0] fault_mask;  // per-vector output inversion
    int          sel;
    int          s_din, s_err, s_fvec;
    logic        s_busy, s_done, s_pass, s_fev;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic gold(input int fn, input int n, input int v);
        int all_ones;
        all_ones = (1 << n) - 1;
        case (fn)
            0:       return v == all_ones;
            1:       return v != 0;
            2:       return ($countones(v) % 2) == 1;
            3:       return v != all_ones;
            4:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb dout_a = gold(dut_fn, 2, int'(din_a)) ^ fault_mask[din_a];
    always_comb dout_b = gold(dut_fn, 3, int'(din_b)) ^ fault_mask[din_b];
    always_comb dout_c = gold(dut_fn, 4, int'(din_c)) ^ fault_mask[din_c];

    always_comb begin
        case (sel)
            1: begin
                s_din = int'(din_b); s_err = int'(err_b); s_fvec = int'(fvec_b);
                s_busy = busy_b; s_done = done_b; s_pass = pass_b; s_fev = fev_b;
            end
            2: begin
                s_din = int'(din_c); s_err = int'(err_c); s_fvec = int'(fvec_c);
                s_busy = busy_c; s_done = done_c; s_pass = pass_c; s_fev = fev_c;
            end
            default: begin
                s_din = int'(din_a); s_err = int'(err_a); s_fvec = int'(fvec_a);
                s_busy = busy_a; s_done = done_a; s_pass = pass_a; s_fev = fev_a;
            end
        endcase
    end

    gate_sweep_checker #(.N_IN(2), .DWELL(5), .ERR_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
        .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_valid(fev_a),
        .first_err_vec(fvec_a)
    );

    gate_sweep_checker #(.N_IN(3), .DWELL(5), .ERR_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
        .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_valid(fev_b),
        .first_err_vec(fvec_b)
    );

    gate_sweep_checker #(.N_IN(4), .DWELL(3), .ERR_W(2)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]),
        .dut_in(din_c), .dut_out(dout_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_count(err_c), .first_err_valid(fev_c),
        .first_err_vec(fvec_c)
    );

    // Leaves the bench at the sample point of the first cycle after the accepting edge.
    task automatic pulse_start(input int which, input int m);
        @(negedge clk);
        start_v[which] = 1'b1;
        mode_v[which]  = 2'(m);
        @(negedge clk);
        start_v[which] = 1'b0;
    endtask

    task automatic run_sweep(input string name, input int which, input int n,
                             input int dwell, input int errmax, input int m,
                             input bit disturb);
        int total, exp_err, first, sat_exp, bad_j, bad_din;
        bit seq_ok;
        total   = (1 << n) * dwell;
        exp_err = 0;
        first   = -1;
        for (int v = 0; v < (1 << n); v++) begin
            if ((gold(dut_fn, n, v) ^ fault_mask[v]) != gold(m, n, v)) begin
                exp_err++;
                if (first < 0) first = v;
            end
        end
        sat_exp = (exp_err > errmax) ? errmax : exp_err;
        sel = which;
        pulse_start(which, m);

        n_vec++;
        if (s_done !== 1'b0 || s_err != 0 || s_fev !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept-clear: done=%b err=%0d fev=%b, want 0/0/0",
                     name, s_done, s_err, s_fev);
        end

        seq_ok  = 1'b1;
        bad_j   = 0;
        bad_din = 0;
        for (int j = 1; j <= total; j++) begin
            if (j > 1) @(negedge clk);
            if (seq_ok && !(s_busy === 1'b1 && s_done === 1'b0 && s_din == (j - 1) / dwell)) begin
                seq_ok  = 1'b0;
                bad_j   = j;
                bad_din = s_din;
            end
            if (disturb) begin
                mode_v[which]  = 2'($urandom);
                start_v[which] = ($urandom_range(3) == 0);
            end
        end
        start_v[which] = 1'b0;

        n_vec++;
        if (!seq_ok) begin
            n_err++;
            $display("FAIL %s sequence: cycle %0d dut_in=%0d busy=%b, want dut_in=%0d busy=1",
                     name, bad_j, bad_din, s_busy, (bad_j - 1) / dwell);
        end

        @(negedge clk);
        n_vec++;
        if (s_busy !== 1'b0 || s_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s end-status: busy=%b done=%b, want 0/1", name, s_busy, s_done);
        end
        n_vec++;
        if (s_pass !== (exp_err == 0)) begin
            n_err++;
            $display("FAIL %s pass: got %b want %b", name, s_pass, (exp_err == 0));
        end
        n_vec++;
        if (s_err != sat_exp) begin
            n_err++;
            $display("FAIL %s err_count: got %0d want %0d", name, s_err, sat_exp);
        end
        n_vec++;
        if (s_fev !== (exp_err > 0) || s_fvec != ((first < 0) ? 0 : first)) begin
            n_err++;
            $display("FAIL %s first_err: got valid=%b vec=%0d want valid=%b vec=%0d",
                     name, s_fev, s_fvec, (exp_err > 0), (first < 0) ? 0 : first);
        end
        n_vec++;
        if (s_din != (1 << n) - 1) begin
            n_err++;
            $display("FAIL %s dut_in-hold: got %0d want %0d", name, s_din, (1 << n) - 1);
        end

        @(negedge clk);
        n_vec++;
        if (s_done !== 1'b1 || s_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done-held: done=%b busy=%b, want 1/0", name, s_done, s_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 2'd0;
        end
        dut_fn     = 0;
        fault_mask = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            n_vec++;
            if ({s_busy, s_done, s_pass, s_fev} !== 4'b0 || s_din != 0 || s_err != 0 || s_fvec != 0) begin
                n_err++;
                $display("FAIL reset inst%0d: busy=%b done=%b pass=%b fev=%b din=%0d err=%0d fvec=%0d, want all 0",
                         i, s_busy, s_done, s_pass, s_fev, s_din, s_err, s_fvec);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_good_and();
        dut_fn = 0; fault_mask = '0;
        run_sweep("good_and", 0, 2, 5, 255, 0, 1'b0);
    endtask

    task automatic test_stuck_at_1();
        dut_fn = 4; fault_mask = '0;
        run_sweep("stuck1", 0, 2, 5, 255, 0, 1'b0);
    endtask

    task automatic test_xor_disturbed();
        dut_fn = 2; fault_mask = '0;
        run_sweep("xor_disturb", 1, 3, 5, 255, 2, 1'b1);
    endtask

    task automatic test_saturation();
        dut_fn = 0; fault_mask = '0;
        run_sweep("saturate", 2, 4, 3, 3, 3, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        bit saw_done;
        dut_fn = 0; fault_mask = '0;
        sel = 0;
        pulse_start(0, 0);
        for (int k = 0; k < 40 && s_din != 2; k++) @(negedge clk);
        n_vec++;
        if (s_din != 2 || s_busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst reach-vec2: dut_in=%0d busy=%b, want 2/1", s_din, s_busy);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({s_busy, s_done, s_pass, s_fev} !== 4'b0 || s_din != 0 || s_err != 0 || s_fvec != 0) begin
            n_err++;
            $display("FAIL midrst async-clear: busy=%b done=%b pass=%b din=%0d err=%0d, want all 0",
                     s_busy, s_done, s_pass, s_din, s_err);
        end
        #1 rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (s_done === 1'b1 || s_busy === 1'b1) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done) begin
            n_err++;
            $display("FAIL midrst idle-after: busy/done seen 1, want 0");
        end
        run_sweep("after_rst", 0, 2, 5, 255, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        dut_fn = 1; fault_mask = '0;
        run_sweep("b2b_first", 0, 2, 5, 255, 1, 1'b0);
        fault_mask = 16'h0004;
        run_sweep("b2b_faulty", 0, 2, 5, 255, 1, 1'b0);
        fault_mask = '0;
        run_sweep("b2b_clean", 0, 2, 5, 255, 1, 1'b0);
    endtask

    task automatic test_random();
        int which, n, dwell, errmax, m;
        for (int r = 0; r < 8; r++) begin
            which  = $urandom_range(2);
            n      = (which == 0) ? 2 : (which == 1) ? 3 : 4;
            dwell  = (which == 2) ? 3 : 5;
            errmax = (which == 2) ? 3 : 255;
            m      = $urandom_range(3);
            dut_fn = $urandom_range(5);
            fault_mask = ($urandom_range(1) == 1) ? 16'($urandom) : 16'h0;
            run_sweep($sformatf("rand%0d", r), which, n, dwell, errmax, m, $urandom_range(1) == 1);
        end
    endtask

    initial begin
        test_reset();
        test_good_and();
        test_stuck_at_1();
        test_xor_disturbed();
        test_saturation();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
